// File: rtl/fp_divider_if.sv
// ----------------------------------------------------------------------------
// fp_divider_if
//   Start/ready request bus between the FP execute path and fp_divider.
//   The requester drives a, b and start. The divider returns out and ready.
//
//   a      N_BIT  dividend, sampled on the accepting edge
//   b      N_BIT  divisor, sampled on the accepting edge
//   start  1      request; accepted on a clk edge where ready=1
//   out    N_BIT  quotient; stable from one completion to the next
//   ready  1      1 = idle and out valid, 0 = busy
//
//   Modports: master (requester side), slave (divider side).
// ----------------------------------------------------------------------------
interface fp_divider_if #(
    parameter int N_BIT = 32
);
    logic [N_BIT-1:0] a;
    logic [N_BIT-1:0] b;
    logic             start;
    logic [N_BIT-1:0] out;
    logic             ready;

    modport master (
        output a,
        output b,
        output start,
        input  out,
        input  ready
    );

    modport slave (
        input  a,
        input  b,
        input  start,
        output out,
        output ready
    );
endinterface

// File: rtl/fp_divider.sv
// ----------------------------------------------------------------------------
// fp_divider
//   Iterative IEEE-754 divider, out = a / b, with round-to-nearest-even.
//   A radix-2 restoring divider produces one quotient bit per cycle.
//   Operand formats, special-value encodings and the handshake match fpmul.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; an operation in flight is dropped
//   bus    fp_divider_if.slave: a, b, start in; out, ready out
//
//   State sequence: IDLE -> NORM -> DIV -> ROUND -> IDLE.
//   Special operands go from IDLE directly to ROUND.
// ----------------------------------------------------------------------------
module fp_divider #(
    parameter int LOG_BIT = 5,
    parameter int EXP_BIT = 8,
    parameter int N_BIT   = 1 << LOG_BIT,
    parameter int MAN_BIT = N_BIT - EXP_BIT - 1
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_divider_if.slave bus
);

    localparam int SIG_W = MAN_BIT + 1;   // hidden + fraction
    localparam int REM_W = MAN_BIT + 2;   // dividend / partial remainder
    localparam int Q_W   = MAN_BIT + 3;   // hidden + fraction + guard + round
    localparam int E_W   = EXP_BIT + 2;   // signed working exponent
    localparam int CNT_W = LOG_BIT + 1;
    localparam int BIAS  = (1 << (EXP_BIT - 1)) - 1;

    localparam logic signed [E_W-1:0] E_ONE    = E_W'(1);
    localparam logic signed [E_W-1:0] E_BIAS   = E_W'(BIAS);
    localparam logic        [E_W-1:0] EXP_MAX  = {2'b00, {EXP_BIT{1'b1}}};
    localparam logic        [E_W-1:0] SH_MAX   = E_W'(Q_W);
    localparam logic      [CNT_W-1:0] CNT_LAST = CNT_W'(Q_W - 1);
    localparam logic        [Q_W-1:0] Q_ONES   = '1;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DIV,
        ROUND
    } state_t;

    state_t                 state;
    logic                   phase;
    logic                   ready_r;
    logic [N_BIT-1:0]       out_r;
    logic                   sign;
    logic                   special;
    logic [N_BIT-1:0]       special_val_r;
    logic [REM_W-1:0]       ma;
    logic [SIG_W-1:0]       mb;
    logic signed [E_W-1:0]  ea;
    logic signed [E_W-1:0]  eb;
    logic signed [E_W-1:0]  e;
    logic [Q_W-1:0]         q;
    logic                   sticky;
    logic [CNT_W-1:0]       cnt;
    logic [E_W-1:0]         exp_r;

    assign bus.out   = out_r;
    assign bus.ready = ready_r;

    // ------------------------------------------------------------------
    // Operand unpack and classification
    // ------------------------------------------------------------------
    logic                  sign_a, sign_b, s_in;
    logic [EXP_BIT-1:0]    exp_a, exp_b;
    logic [MAN_BIT-1:0]    frac_a, frac_b;
    logic                  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic                  is_special;
    logic [N_BIT-1:0]      special_val;
    logic [SIG_W-1:0]      sig_a, sig_b;
    logic signed [E_W-1:0] eff_exp_a, eff_exp_b;

    always_comb begin
        sign_a = bus.a[N_BIT-1];
        sign_b = bus.b[N_BIT-1];
        exp_a  = bus.a[N_BIT-2:MAN_BIT];
        exp_b  = bus.b[N_BIT-2:MAN_BIT];
        frac_a = bus.a[MAN_BIT-1:0];
        frac_b = bus.b[MAN_BIT-1:0];
        s_in   = sign_a ^ sign_b;

        nan_a  = (&exp_a) & (|frac_a);
        nan_b  = (&exp_b) & (|frac_b);
        inf_a  = (&exp_a) & ~(|frac_a);
        inf_b  = (&exp_b) & ~(|frac_b);
        zero_a = ~(|exp_a) & ~(|frac_a);
        zero_b = ~(|exp_b) & ~(|frac_b);

        is_special  = 1'b1;
        special_val = '0;
        if (nan_a | nan_b | (inf_a & inf_b) | (zero_a & zero_b)) begin
            special_val = {s_in, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT-1){1'b0}}};
        end else if (inf_a | zero_b) begin
            special_val = {s_in, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
        end else if (inf_b | zero_a) begin
            special_val = {s_in, {(N_BIT-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end

        // Denormals carry hidden=0 and behave as exponent 1.
        sig_a     = {|exp_a, frac_a};
        sig_b     = {|exp_b, frac_b};
        eff_exp_a = (|exp_a) ? {2'b00, exp_a} : E_ONE;
        eff_exp_b = (|exp_b) ? {2'b00, exp_b} : E_ONE;
    end

    // ------------------------------------------------------------------
    // NORM step: shift any significand whose MSB is clear
    // ------------------------------------------------------------------
    logic [REM_W-1:0]      ma_n;
    logic [SIG_W-1:0]      mb_n;
    logic signed [E_W-1:0] ea_n, eb_n, e_raw;
    logic                  norm_done, ma_lt;

    always_comb begin
        ma_n      = ma[SIG_W-1] ? ma : (ma << 1);
        ea_n      = ma[SIG_W-1] ? ea : (ea - E_ONE);
        mb_n      = mb[SIG_W-1] ? mb : (mb << 1);
        eb_n      = mb[SIG_W-1] ? eb : (eb - E_ONE);
        norm_done = ma_n[SIG_W-1] & mb_n[SIG_W-1];
        e_raw     = ea_n - eb_n + E_BIAS;
        ma_lt     = ma_n[SIG_W-1:0] < mb_n;
    end

    // ------------------------------------------------------------------
    // DIV step: restoring subtract
    // ------------------------------------------------------------------
    logic             div_ge;
    logic [REM_W-1:0] rem_diff;

    always_comb begin
        div_ge   = ma >= {1'b0, mb};
        rem_diff = div_ge ? (ma - {1'b0, mb}) : ma;
    end

    // ------------------------------------------------------------------
    // ROUND, first cycle: denormalise on underflow
    // ------------------------------------------------------------------
    logic           e_nonpos;
    logic [E_W-1:0] sh_amt;
    logic [Q_W-1:0] q_sh;
    logic           lost;
    logic [E_W-1:0] exp0;

    always_comb begin
        e_nonpos = e[E_W-1] | (e == '0);
        sh_amt   = E_ONE - e;
        q_sh     = q;
        lost     = 1'b0;
        exp0     = e;
        if (e_nonpos) begin
            exp0 = '0;
            if (sh_amt > SH_MAX) begin
                q_sh = '0;
                lost = 1'b1;
            end else begin
                q_sh = q >> sh_amt;
                lost = |(q & ~(Q_ONES << sh_amt));
            end
        end
    end

    // ------------------------------------------------------------------
    // ROUND, second cycle: RNE increment and pack
    // ------------------------------------------------------------------
    logic [SIG_W-1:0]   sig_r;
    logic               round_inc;
    logic [SIG_W:0]     sum;
    logic [E_W-1:0]     exp_f;
    logic [MAN_BIT-1:0] frac_f;
    logic [N_BIT-1:0]   packed_val;

    always_comb begin
        sig_r     = q[Q_W-1:2];
        round_inc = q[1] & (sig_r[0] | q[0] | sticky);
        sum       = {1'b0, sig_r} + {{SIG_W{1'b0}}, round_inc};
        // Carry out bumps the exponent; a denormal rounding into the
        // hidden position becomes the smallest normal (exp field 1).
        exp_f     = exp_r + E_W'(sum[SIG_W])
                          + E_W'((exp_r == '0) && sum[SIG_W-1]);
        frac_f    = sum[SIG_W] ? '0 : sum[MAN_BIT-1:0];
        if (exp_f >= EXP_MAX) begin
            packed_val = {sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
        end else begin
            packed_val = {sign, exp_f[EXP_BIT-1:0], frac_f};
        end
    end

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    // ROUND spans two cycles (denormalise, then round/pack), which gives
    // the t+2 special and t+MAN_BIT+6 normal completion latencies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            phase         <= 1'b0;
            ready_r       <= 1'b1;
            out_r         <= '0;
            sign          <= 1'b0;
            special       <= 1'b0;
            special_val_r <= '0;
            ma            <= '0;
            mb            <= '0;
            ea            <= '0;
            eb            <= '0;
            e             <= '0;
            q             <= '0;
            sticky        <= 1'b0;
            cnt           <= '0;
            exp_r         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ready_r       <= 1'b0;
                        sign          <= s_in;
                        special       <= is_special;
                        special_val_r <= special_val;
                        ma            <= {1'b0, sig_a};
                        mb            <= sig_b;
                        ea            <= eff_exp_a;
                        eb            <= eff_exp_b;
                        phase         <= 1'b0;
                        state         <= is_special ? ROUND : NORM;
                    end
                end
                NORM: begin
                    ma <= ma_n;
                    mb <= mb_n;
                    ea <= ea_n;
                    eb <= eb_n;
                    if (norm_done) begin
                        cnt   <= '0;
                        state <= DIV;
                        if (ma_lt) begin
                            ma <= ma_n << 1;
                            e  <= e_raw - E_ONE;
                        end else begin
                            e  <= e_raw;
                        end
                    end
                end
                DIV: begin
                    ma  <= rem_diff << 1;
                    q   <= {q[Q_W-2:0], div_ge};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        sticky <= |rem_diff;
                        phase  <= 1'b0;
                        state  <= ROUND;
                    end
                end
                ROUND: begin
                    if (!phase) begin
                        q      <= q_sh;
                        sticky <= sticky | lost;
                        exp_r  <= exp0;
                        phase  <= 1'b1;
                    end else begin
                        out_r   <= special ? special_val_r : packed_val;
                        ready_r <= 1'b1;
                        phase   <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// ----------------------------------------------------------------------------
// tb_fp_divider
//   Directed bench for fp_divider: reset, normal quotients, specials,
//   range limits, busy-start, mid-operation reset and back-to-back ops.
// ----------------------------------------------------------------------------
module tb_fp_divider;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fp_divider_if #(.N_BIT(32)) bus ();

    fp_divider #(
        .LOG_BIT(5),
        .EXP_BIT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Launch one operation and wait (bounded) for completion.
    // lat = edges from the accepting edge to ready high, -1 on timeout.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                lat = c;
                break;
            end
        end
        res = bus.out;
    endtask

    task automatic test_reset;
        bus.a     = '0;
        bus.b     = '0;
        bus.start = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want=1", bus.ready);
        end
        checks++;
        if (bus.out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got=%h want=00000000", bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal;
        logic [31:0] res;
        int lat;
        run_op(32'h3F800000, 32'h3F800000, res, lat);
        checks++;
        if (res !== 32'h3F800000) begin
            errors++;
            $display("FAIL one_div_one got=%h want=3F800000", res);
        end
        checks++;
        if (lat !== 29) begin
            errors++;
            $display("FAIL one_div_one_latency got=%0d want=29", lat);
        end
        run_op(32'h3F800000, 32'h40400000, res, lat);
        checks++;
        if (res !== 32'h3EAAAAAB) begin
            errors++;
            $display("FAIL one_div_three got=%h want=3EAAAAAB", res);
        end
        checks++;
        if (lat !== 29) begin
            errors++;
            $display("FAIL one_div_three_latency got=%0d want=29", lat);
        end
        run_op(32'h40C00000, 32'hC0000000, res, lat);
        checks++;
        if (res !== 32'hC0400000) begin
            errors++;
            $display("FAIL six_div_neg_two got=%h want=C0400000", res);
        end
    endtask

    task automatic test_special;
        logic [31:0] sa [4] = '{32'h00000000, 32'h3F800000, 32'h7FC00000, 32'h7F800000};
        logic [31:0] sb [4] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'hC0000000};
        logic [31:0] se [4] = '{32'h7FC00000, 32'h7F800000, 32'h7FC00000, 32'hFF800000};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(sa[i], sb[i], res, lat);
            checks++;
            if (res !== se[i]) begin
                errors++;
                $display("FAIL special_%0d got=%h want=%h", i, res, se[i]);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL special_%0d_latency got=%0d want=2", i, lat);
            end
        end
    endtask

    task automatic test_range;
        logic [31:0] res;
        int lat;
        run_op(32'h7F7FFFFF, 32'h3F000000, res, lat);
        checks++;
        if (res !== 32'h7F800000) begin
            errors++;
            $display("FAIL overflow got=%h want=7F800000", res);
        end
        run_op(32'h00800000, 32'h40000000, res, lat);
        checks++;
        if (res !== 32'h00400000) begin
            errors++;
            $display("FAIL underflow got=%h want=00400000", res);
        end
        checks++;
        if (lat !== 29) begin
            errors++;
            $display("FAIL underflow_latency got=%0d want=29", lat);
        end
        run_op(32'h00000001, 32'h00000001, res, lat);
        checks++;
        if (res !== 32'h3F800000) begin
            errors++;
            $display("FAIL denorm_div got=%h want=3F800000", res);
        end
        checks++;
        if (lat !== 51) begin
            errors++;
            $display("FAIL denorm_latency got=%0d want=51", lat);
        end
    endtask

    task automatic test_busy_start;
        int lat;
        @(negedge clk);
        bus.a     = 32'h3F800000;
        bus.b     = 32'h40400000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            if (c == 8) begin
                @(negedge clk);
                bus.a     = 32'h40C00000;
                bus.b     = 32'hC0000000;
                bus.start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.ready) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (bus.out !== 32'h3EAAAAAB) begin
            errors++;
            $display("FAIL busy_start_result got=%h want=3EAAAAAB", bus.out);
        end
        checks++;
        if (lat !== 29) begin
            errors++;
            $display("FAIL busy_start_latency got=%0d want=29", lat);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        int lat;
        @(negedge clk);
        bus.a     = 32'h3F800000;
        bus.b     = 32'h3F800000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready got=%b want=1", bus.ready);
        end
        checks++;
        if (bus.out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_out got=%h want=00000000", bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h40C00000, 32'hC0000000, res, lat);
        checks++;
        if (res !== 32'hC0400000) begin
            errors++;
            $display("FAIL after_reset_result got=%h want=C0400000", res);
        end
        checks++;
        if (lat !== 29) begin
            errors++;
            $display("FAIL after_reset_latency got=%0d want=29", lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] held;
        int lat;
        bit stable;
        @(negedge clk);
        bus.a     = 32'h3F800000;
        bus.b     = 32'h3F800000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 32'h3F800000;
        bus.b = 32'h40400000;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 29) begin
            errors++;
            $display("FAIL b2b_first_latency got=%0d want=29", lat);
        end
        checks++;
        if (bus.out !== 32'h3F800000) begin
            errors++;
            $display("FAIL b2b_first_result got=%h want=3F800000", bus.out);
        end
        held = bus.out;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept ready=%b want=0", bus.ready);
        end
        stable = 1'b1;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                lat = c;
                break;
            end
            if (bus.out !== held) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL b2b_out_stable got=%b want=1", stable);
        end
        checks++;
        if (lat !== 29) begin
            errors++;
            $display("FAIL b2b_second_latency got=%0d want=29", lat);
        end
        checks++;
        if (bus.out !== 32'h3EAAAAAB) begin
            errors++;
            $display("FAIL b2b_second_result got=%h want=3EAAAAAB", bus.out);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
